ysyx_22050710_csr: RTL and testbench
====================================

# ysyx_22050710_csr

Machine-mode CSR file for the ysyx_22050710 core, in the ID stage alongside the exception unit. Holds mstatus, mtvec, mepc, mcause, mcycle and read-only mhartid. Executes Zicsr read-modify-write operations and performs trap entry and return state updates for ecall and mret. Drives the mtvec/mepc values that the exception unit uses to form the trap or return next-PC.

## Interface
- CSR_WD, 64, CSR and data width
- PC_WD, 64, PC width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  instruction in ID retires this cycle; gates all architectural updates
- i_csr_addr  in  12  CSR address
- i_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- i_csr_wdata  in  CSR_WD  rs1 value, or zimm zero-extended
- i_ecall_sel  in  1  ecall decoded
- i_mret_sel  in  1  mret decoded
- i_pc  in  PC_WD  PC of the current instruction
- o_csr_rdata  out  CSR_WD  old value of the addressed CSR, for rd
- o_mtvec  out  CSR_WD  current mtvec register
- o_mepc  out  CSR_WD  current mepc register
- o_illegal  out  1  CSR access to an unimplemented or read-only-written address

## Operation
- Address map:
  - 0x300 mstatus
  - 0x305 mtvec
  - 0x341 mepc
  - 0x342 mcause
  - 0xB00 mcycle
  - 0xF14 mhartid (reads 0, read-only)
- New value by op:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - RS/RC with wdata==0 perform no write.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] is fixed at 2'b11. Bits [35:32] are fixed at 4'ha. All other bits are 0.
  - mtvec[1:0] and mepc[1:0] are forced to 0 on every write.
  - mcause and mcycle are fully writable.
- o_illegal = i_valid & op!=0 & (address unmapped | (address==0xF14 & write would occur)).
  - When o_illegal is 1: o_csr_rdata=0 and no state changes.
- ecall (trap entry): mepc<=i_pc, mcause<=11, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority when several are asserted: ecall > mret > CSR op. A lower-priority CSR write is dropped entirely.
- i_valid=0: no CSR, trap, or return update, and o_illegal=0.
- mcycle:
  - Increments by 1 every cycle, regardless of i_valid, wrapping at 2^64.
  - A CSR write in a cycle replaces the increment: mcycle<=written value.

## Timing
- o_csr_rdata is combinational from current state. It is the pre-write value, with zero read latency.
- All updates take effect at the rising edge. New values are visible on o_csr_rdata, o_mtvec and o_mepc the next cycle.
- o_mtvec and o_mepc come directly from the registers, with no bypass. Consequences:
  - A csrw mtvec followed immediately by ecall traps to the new mtvec.
  - An ecall in the same cycle as the mtvec write is impossible, because the op is dropped.
- Reset: the edge with i_rst_n=0 overrides every write, trap and increment.
- Reset values:
  - mstatus=64'h0000_000a_0000_1800
  - mtvec=0, mepc=0, mcause=0, mcycle=0
  - o_illegal follows its inputs and is 0 when i_valid=0.
- Reset mid-sequence (e.g. the cycle of ecall) discards that ecall. The first post-reset cycle shows reset values.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1, i_ecall_sel=1, then release.
  - mstatus reads 0xa00001800.
  - mtvec, mepc and mcause read 0.
  - mcycle reads 0, 1, 2 in the following cycles.
- csrrw mtvec with wdata 0x80000103:
  - o_csr_rdata=0 in that cycle.
  - Next cycle o_mtvec=0x80000100.
- csrrs mstatus 0x8, then ecall at pc 0x80000010, then mret:
  - After ecall: mepc=0x80000010, mcause=11, mstatus=0xa00001880.
  - After mret: mstatus=0xa00001888.
- csrrc mcause with wdata 0 (mcause=11): o_csr_rdata=11 and mcause is unchanged. Simultaneous ecall (pc 0x80000020) and csrrw mepc 0x1234: mepc=0x80000020.
- Illegal accesses: csrrw 0x7C0 and csrrw 0xF14 each give o_illegal=1, o_csr_rdata=0, no state change. csrrs 0xF14 with wdata 0 gives o_illegal=0 and reads 0.
- csrrw mcycle 5: reads 5 the next cycle and 6 the cycle after. With i_valid=0 and ecall asserted, mepc is unchanged and mcycle keeps counting.

Source files
------------

// File: rtl/ysyx_22050710_csr.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause/mcycle/mhartid with Zicsr
// read-modify-write, ecall trap entry and mret return updates.
module ysyx_22050710_csr #(
   parameter int CSR_WD = 64,
   parameter int PC_WD  = 64
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [11:0]       i_csr_addr,
   input  logic [1:0]        i_csr_op,
   input  logic [CSR_WD-1:0] i_csr_wdata,
   input  logic              i_ecall_sel,
   input  logic              i_mret_sel,
   input  logic [PC_WD-1:0]  i_pc,
   output logic [CSR_WD-1:0] o_csr_rdata,
   output logic [CSR_WD-1:0] o_mtvec,
   output logic [CSR_WD-1:0] o_mepc,
   output logic              o_illegal
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
   localparam logic [11:0] ADDR_MHARTID = 12'hF14;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam logic [CSR_WD-1:0] ALIGN_MASK   = ~CSR_WD'(3);
   localparam logic [CSR_WD-1:0] CAUSE_ECALL  = CSR_WD'(11);

   // Only MIE and MPIE are stored; the rest of mstatus is constant.
   logic              mie_q,    mie_d;
   logic              mpie_q,   mpie_d;
   logic [CSR_WD-1:0] mtvec_q,  mtvec_d;
   logic [CSR_WD-1:0] mepc_q,   mepc_d;
   logic [CSR_WD-1:0] mcause_q, mcause_d;
   logic [CSR_WD-1:0] mcycle_q, mcycle_d;

   logic              sel_mstatus, sel_mtvec, sel_mepc, sel_mcause, sel_mcycle, sel_mhartid;
   logic              mapped;
   logic [CSR_WD-1:0] mstatus_val;
   logic [CSR_WD-1:0] old_val;
   logic [CSR_WD-1:0] new_val;
   logic              wr_req;
   logic              illegal;
   logic              take_ecall;
   logic              take_mret;
   logic              csr_wr;

   always_comb begin
      mstatus_val         = '0;
      mstatus_val[35:32]  = 4'ha;
      mstatus_val[12:11]  = 2'b11;
      mstatus_val[7]      = mpie_q;
      mstatus_val[3]      = mie_q;
   end

   always_comb begin
      sel_mstatus = (i_csr_addr == ADDR_MSTATUS);
      sel_mtvec   = (i_csr_addr == ADDR_MTVEC);
      sel_mepc    = (i_csr_addr == ADDR_MEPC);
      sel_mcause  = (i_csr_addr == ADDR_MCAUSE);
      sel_mcycle  = (i_csr_addr == ADDR_MCYCLE);
      sel_mhartid = (i_csr_addr == ADDR_MHARTID);
      mapped      = sel_mstatus | sel_mtvec | sel_mepc | sel_mcause | sel_mcycle | sel_mhartid;
   end

   always_comb begin
      old_val = '0;
      unique case (1'b1)
         sel_mstatus: old_val = mstatus_val;
         sel_mtvec:   old_val = mtvec_q;
         sel_mepc:    old_val = mepc_q;
         sel_mcause:  old_val = mcause_q;
         sel_mcycle:  old_val = mcycle_q;
         default:     old_val = '0;
      endcase
   end

   always_comb begin
      new_val = old_val;
      case (i_csr_op)
         OP_RW:   new_val = i_csr_wdata;
         OP_RS:   new_val = old_val | i_csr_wdata;
         OP_RC:   new_val = old_val & ~i_csr_wdata;
         default: new_val = old_val;
      endcase
   end

   // RS/RC with a zero operand are pure reads, so they may target mhartid.
   always_comb begin
      wr_req     = (i_csr_op == OP_RW) |
                   (((i_csr_op == OP_RS) | (i_csr_op == OP_RC)) & (|i_csr_wdata));
      illegal    = i_valid & (i_csr_op != OP_NONE) & (~mapped | (sel_mhartid & wr_req));
      take_ecall = i_valid & i_ecall_sel;
      take_mret  = i_valid & i_mret_sel & ~i_ecall_sel;
      csr_wr     = i_valid & (i_csr_op != OP_NONE) & wr_req & ~illegal &
                   ~i_ecall_sel & ~i_mret_sel;
   end

   always_comb begin
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      mtvec_d  = mtvec_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mcycle_d = mcycle_q + CSR_WD'(1);
      if (take_ecall) begin
         mepc_d   = CSR_WD'(i_pc) & ALIGN_MASK;
         mcause_d = CAUSE_ECALL;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (take_mret) begin
         mie_d    = mpie_q;
         mpie_d   = 1'b1;
      end else if (csr_wr) begin
         if (sel_mstatus) begin
            mie_d  = new_val[3];
            mpie_d = new_val[7];
         end
         if (sel_mtvec)  mtvec_d  = new_val & ALIGN_MASK;
         if (sel_mepc)   mepc_d   = new_val & ALIGN_MASK;
         if (sel_mcause) mcause_d = new_val;
         if (sel_mcycle) mcycle_d = new_val;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mtvec_q  <= '0;
         mepc_q   <= '0;
         mcause_q <= '0;
         mcycle_q <= '0;
      end else begin
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mcycle_q <= mcycle_d;
      end
   end

   assign o_csr_rdata = illegal ? '0 : old_val;
   assign o_illegal   = illegal;
   assign o_mtvec     = mtvec_q;
   assign o_mepc      = mepc_q;

endmodule

// File: tb/tb_ysyx_22050710_csr.sv
// Directed bench for ysyx_22050710_csr: expectations are queued when a step is
// driven and popped/compared while that step's outputs are stable.
module tb_ysyx_22050710_csr;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [11:0] i_csr_addr;
   logic [1:0]  i_csr_op;
   logic [63:0] i_csr_wdata;
   logic        i_ecall_sel;
   logic        i_mret_sel;
   logic [63:0] i_pc;
   logic [63:0] o_csr_rdata;
   logic [63:0] o_mtvec;
   logic [63:0] o_mepc;
   logic        o_illegal;

   int total = 0;
   int bad   = 0;

   localparam int S_RDATA = 0;
   localparam int S_MTVEC = 1;
   localparam int S_MEPC  = 2;
   localparam int S_ILL   = 3;

   typedef struct {
      string       tag;
      int          src;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];

   ysyx_22050710_csr #(.CSR_WD(64), .PC_WD(64)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .i_csr_addr  (i_csr_addr),
      .i_csr_op    (i_csr_op),
      .i_csr_wdata (i_csr_wdata),
      .i_ecall_sel (i_ecall_sel),
      .i_mret_sel  (i_mret_sel),
      .i_pc        (i_pc),
      .o_csr_rdata (o_csr_rdata),
      .o_mtvec     (o_mtvec),
      .o_mepc      (o_mepc),
      .o_illegal   (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic push(input string tag, input int src, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.src = src;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.src)
            S_RDATA: obs = o_csr_rdata;
            S_MTVEC: obs = o_mtvec;
            S_MEPC:  obs = o_mepc;
            default: obs = {63'b0, o_illegal};
         endcase
         total++;
         assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] op,
                        input logic [63:0] wd, input logic ec, input logic mr,
                        input logic [63:0] pc);
      i_valid     = v;
      i_csr_addr  = a;
      i_csr_op    = op;
      i_csr_wdata = wd;
      i_ecall_sel = ec;
      i_mret_sel  = mr;
      i_pc        = pc;
   endtask

   // Compare queued expectations mid-cycle, then advance past the next edge.
   task automatic cyc();
      @(negedge i_clk);
      drain();
      @(posedge i_clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
      drive(1'b1, a, 2'b10, 64'h0, 1'b0, 1'b0, 64'h0);
      push(tag, S_RDATA, exp);
      push({tag, "_ill"}, S_ILL, 64'h0);
      cyc();
   endtask

   initial begin
      i_rst_n = 1'b0;
      drive(1'b1, 12'h000, 2'b00, 64'h0, 1'b1, 1'b0, 64'h8000_0abc);
      @(posedge i_clk);
      #1;
      cyc();
      cyc();
      i_rst_n = 1'b1;

      rd(12'hB00, "rst_mcycle0", 64'd0);
      rd(12'hB00, "rst_mcycle1", 64'd1);
      rd(12'hB00, "rst_mcycle2", 64'd2);
      rd(12'h300, "rst_mstatus", 64'h0000_000a_0000_1800);
      rd(12'h305, "rst_mtvec",   64'h0);
      rd(12'h341, "rst_mepc",    64'h0);
      rd(12'h342, "rst_mcause",  64'h0);

      drive(1'b1, 12'h305, 2'b01, 64'h8000_0103, 1'b0, 1'b0, 64'h0);
      push("csrrw_mtvec_old", S_RDATA, 64'h0);
      push("csrrw_mtvec_reg", S_MTVEC, 64'h0);
      cyc();
      push("mtvec_out", S_MTVEC, 64'h8000_0100);
      rd(12'h305, "mtvec_read", 64'h8000_0100);

      drive(1'b1, 12'h300, 2'b10, 64'h8, 1'b0, 1'b0, 64'h0);
      push("csrrs_mstatus_old", S_RDATA, 64'h0000_000a_0000_1800);
      cyc();
      drive(1'b1, 12'h000, 2'b00, 64'h0, 1'b1, 1'b0, 64'h8000_0010);
      push("ecall_mepc_nobypass", S_MEPC, 64'h0);
      push("ecall_mtvec", S_MTVEC, 64'h8000_0100);
      cyc();
      push("ecall_mepc_out", S_MEPC, 64'h8000_0010);
      rd(12'h341, "ecall_mepc",    64'h8000_0010);
      rd(12'h342, "ecall_mcause",  64'd11);
      rd(12'h300, "ecall_mstatus", 64'h0000_000a_0000_1880);
      drive(1'b1, 12'h000, 2'b00, 64'h0, 1'b0, 1'b1, 64'h0);
      cyc();
      rd(12'h300, "mret_mstatus",  64'h0000_000a_0000_1888);

      drive(1'b1, 12'h342, 2'b11, 64'h0, 1'b0, 1'b0, 64'h0);
      push("csrrc0_mcause_old", S_RDATA, 64'd11);
      cyc();
      rd(12'h342, "csrrc0_mcause_kept", 64'd11);

      drive(1'b1, 12'h341, 2'b01, 64'h1234, 1'b1, 1'b0, 64'h8000_0020);
      push("ecall_vs_csrrw_old", S_RDATA, 64'h8000_0010);
      cyc();
      rd(12'h341, "ecall_wins_mepc",    64'h8000_0020);
      rd(12'h300, "ecall2_mstatus",     64'h0000_000a_0000_1880);

      drive(1'b1, 12'h7C0, 2'b01, 64'h5, 1'b0, 1'b0, 64'h0);
      push("ill_7c0_flag",  S_ILL,   64'h1);
      push("ill_7c0_rdata", S_RDATA, 64'h0);
      cyc();
      drive(1'b1, 12'hF14, 2'b01, 64'h1, 1'b0, 1'b0, 64'h0);
      push("ill_f14_flag",  S_ILL,   64'h1);
      push("ill_f14_rdata", S_RDATA, 64'h0);
      cyc();
      rd(12'hF14, "mhartid_read", 64'h0);
      drive(1'b0, 12'h7C0, 2'b01, 64'h5, 1'b0, 1'b0, 64'h0);
      push("ill_gated_by_valid", S_ILL, 64'h0);
      cyc();
      rd(12'h305, "ill_mtvec_kept", 64'h8000_0100);
      rd(12'h341, "ill_mepc_kept",  64'h8000_0020);

      drive(1'b1, 12'hB00, 2'b01, 64'd5, 1'b0, 1'b0, 64'h0);
      cyc();
      rd(12'hB00, "mcycle_wr5", 64'd5);
      rd(12'hB00, "mcycle_6",   64'd6);
      drive(1'b0, 12'h000, 2'b00, 64'h0, 1'b1, 1'b0, 64'h0000_0999);
      cyc();
      rd(12'hB00, "mcycle_8",          64'd8);
      rd(12'h341, "invalid_ecall_mepc", 64'h8000_0020);
      push("invalid_ecall_mepc_out", S_MEPC, 64'h8000_0020);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
